sync_debouncer: RTL
===================

// Module: sync_debouncer
// PURPOSE
//  Front-end conditioner for raw asynchronous inputs (buttons, external strobes).
//  Synchronises din into the clk domain, then filters it with a counter-based FSM.
//  dout changes only after the synchronised input holds a new level for DEBOUNCE_CYCLES clocks.
//  dout is a clean single-domain level that drives the edge-detector stage directly.
// PARAMETERS
//  SYNC_STAGES      2     synchroniser flop count; legal range >= 2
//  CNT_W            16    debounce counter width
//  DEBOUNCE_CYCLES  1000  consecutive stable samples required; 2 <= value <= 2**CNT_W-1
//  RESET_LEVEL      1'b0  level loaded into the synchroniser chain and dout at reset
// PORTS
//  clk         in   1      system clock; all logic on the rising edge
//  rst         in   1      asynchronous, active-low reset
//  din         in   1      raw asynchronous input; no timing relationship to clk
//  dout        out  1      debounced, synchronised level
//  busy        out  1      1 while a candidate transition is being qualified (PEND_* states)
//  glitch_cnt  out  8      rejected-transition count; present only with SYNC_DEBOUNCER_GLITCH_CNT_EN
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - sync chain = RESET_LEVEL; state = STABLE_LO if RESET_LEVEL=0, else STABLE_HI.
//   - cnt = 0; dout = RESET_LEVEL; busy = 0; glitch_cnt = 0.
//   - Reset mid-qualification abandons the pending transition; nothing partial is kept.
//  Synchroniser:
//   - SYNC_STAGES-deep flop chain; s = last stage.
//   - No logic is placed between stages. Only s feeds the FSM.
//  FSM (registered; states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO):
//   - STABLE_LO: if s=1, go to PEND_HI with cnt=1; else stay with cnt=0.
//   - PEND_HI, s=0: back to STABLE_LO with cnt=0 (glitch rejected); dout stays 0.
//   - PEND_HI, s=1, cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI with dout=1 and cnt=0.
//   - PEND_HI, s=1, otherwise: cnt <= cnt+1.
//   - STABLE_HI and PEND_LO mirror the above with the levels inverted.
//  busy = (state==PEND_HI) | (state==PEND_LO); registered with the state.
//  Latency:
//   - din stable from before edge 1 -> dout updates at edge SYNC_STAGES+DEBOUNCE_CYCLES.
//   - Nothing in the path is combinational from din to dout.
//  Boundaries:
//   - cnt never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
//   - Any single opposite sample restarts qualification from scratch (no hysteresis credit).
//   - A bounce that returns to the current dout level inside PEND is a glitch; dout never pulses.
//   - In a STABLE state, s equal to dout keeps cnt=0.
//   - dout is glitch-free: it changes only on the PEND->STABLE transition.
//   - The minimum spacing between dout toggles is DEBOUNCE_CYCLES clocks.
// CONFIGURATION
//  SYNC_DEBOUNCER_GLITCH_CNT_EN defined:
//   - glitch_cnt port and counter exist.
//   - Increments by 1 on each PEND_*->STABLE_* return without a dout change.
//   - Saturates at 8'hFF; cleared only by reset.
//  SYNC_DEBOUNCER_GLITCH_CNT_EN undefined:
//   - Port and counter are absent; all other behaviour is identical.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless noted)
//  1 Reset: hold rst=0, din=1 -> dout=0, busy=0, glitch_cnt=0.
//    Release rst, din=1 steady -> busy=1 from edge 3; dout=1 at edge 6; busy=0 at edge 6.
//  2 Bounce: din high for 2 clocks, low for 1, then high steady
//    -> no dout change during the bounce; dout=1 exactly 6 edges after the final rise.
//    -> glitch_cnt=1.
//  3 Short pulse: din 0->1 for 3 clocks, then 0 -> dout stays 0 throughout.
//    -> busy=1 for 3 clocks; glitch_cnt increments by 1.
//  4 Falling qualify: dout=1, din 1->0 steady -> dout=0 at edge 6; never returns to 1.
//  5 Reset mid-PEND: assert rst while busy=1 with cnt=2 -> immediate dout=0, busy=0.
//    After release with din=1, the full 6-edge latency applies again.
//  6 Saturation (macro on): 300 rejected 1-clock pulses
//    -> glitch_cnt=8'hFF and holds; dout never toggles.
//    RESET_LEVEL=1 variant -> dout=1 out of reset.

Source files
------------

// File: rtl/sync_debouncer.sv
// rtl/sync_debouncer.sv - input synchroniser plus counter-based debounce FSM
// Optional rejected-transition counter: SYNC_DEBOUNCER_GLITCH_CNT_EN
module sync_debouncer #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   CNT_W           = 16,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_t           RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;

    // Plain shift chain: nothing but flops between din and s.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (s) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    dout_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    dout_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= RST_STATE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    // A pending candidate abandoned because s went back to the held level.
    assign glitch = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule
